// File: rtl/proc_pkg.sv
// Shared processor definitions: default datapath widths, PC increment and fetch FSM states.
package proc_pkg;

    localparam int unsigned DEFAULT_ADDR_W  = 32;
    localparam int unsigned DEFAULT_INSTR_W = 32;
    localparam int unsigned PC_STEP         = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DROP = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO buffering fetched {pc, instruction} entries.
// Flush has priority over push and pop; push into a full FIFO is accepted only alongside a pop.
module fetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic [WIDTH-1:0]         o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push_en;
    logic             w_pop_en;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_pop_en  = i_pop && !o_empty;
    assign w_push_en = i_push && (!o_full || w_pop_en);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_en) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop_en)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_push_en) - CNT_W'(w_pop_en);
        end
    end

    // Storage needs no reset: entries are only observed once counted in.
    always_ff @(posedge clk) begin
        if (w_push_en && !i_flush) r_mem[r_wr_ptr] <= i_push_data;
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues one-at-a-time requests to instruction memory, buffers
// returned words and hands {pc, instr} to the decoder; redirect flushes buffered and in-flight words.
module instruction_fetch
    import proc_pkg::*;
#(
    parameter int unsigned       ADDR_W     = DEFAULT_ADDR_W,
    parameter int unsigned       INSTR_W    = DEFAULT_INSTR_W,
    parameter int unsigned       FIFO_DEPTH = 2,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc
);

    localparam int unsigned ENTRY_W = ADDR_W + INSTR_W;
    localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t      r_state;
    fetch_state_t      w_state_nxt;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] w_fetch_pc_nxt;
    logic [ADDR_W-1:0] r_req_pc;
    logic [ADDR_W-1:0] w_req_pc_nxt;
    logic              w_req_fire;
    logic              w_push;
    logic              w_pop;
    logic [ENTRY_W-1:0] w_head;
    logic [CNT_W-1:0]  w_count;
    logic              w_full;
    logic              w_empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_fetch_pc <= RESET_PC;
            r_req_pc   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
            r_req_pc   <= w_req_pc_nxt;
        end
    end

    assign w_req_fire = imem_req_valid && imem_req_ready;

    // Next state, PC update and request gating; redirect overrides the normal flow.
    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_req_pc_nxt   = r_req_pc;
        imem_req_valid = 1'b0;
        w_push         = 1'b0;
        case (r_state)
            S_IDLE: w_state_nxt = S_REQ;
            S_REQ: begin
                imem_req_valid = (w_count < CNT_W'(FIFO_DEPTH));
                if (imem_req_valid && imem_req_ready) begin
                    w_req_pc_nxt   = r_fetch_pc;
                    w_fetch_pc_nxt = r_fetch_pc + ADDR_W'(PC_STEP);
                    w_state_nxt    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    w_push      = 1'b1;
                    w_state_nxt = S_REQ;
                end
            end
            S_DROP: if (imem_rsp_valid) w_state_nxt = S_REQ;
            default: w_state_nxt = S_IDLE;
        endcase
        if (redirect_valid) begin
            w_fetch_pc_nxt = {redirect_pc[ADDR_W-1:2], 2'b00};
            w_push         = 1'b0;
            // A request already issued (or issued now) still owes a response that must be dropped.
            if ((r_state == S_REQ && w_req_fire) || (r_state == S_WAIT && !imem_rsp_valid))
                w_state_nxt = S_DROP;
        end
    end

    assign w_pop = instr_valid && instr_ready && !redirect_valid;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_push_data ({r_req_pc, imem_rsp_data}),
        .i_pop       (w_pop),
        .i_flush     (redirect_valid),
        .o_head      (w_head),
        .o_count     (w_count),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    assign imem_addr   = r_fetch_pc;
    assign instr_valid = !w_empty;
    assign instr_pc    = w_empty ? '0 : w_head[ENTRY_W-1 -: ADDR_W];
    assign instr       = w_empty ? '0 : w_head[INSTR_W-1:0];

    // Responses are only legal while one is owed; the FIFO never overflows.
    a_rsp_owed: assert property (@(posedge clk) disable iff (reset)
        imem_rsp_valid |-> (r_state == S_WAIT || r_state == S_DROP));
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        w_push |-> (!w_full || w_pop));

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus randomized traffic
// checked against a program-order stream model with a random-latency memory.
module tb_instruction_fetch;

    localparam int unsigned AW    = 32;
    localparam int unsigned IW    = 32;
    localparam int unsigned DEPTH = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          imem_req_valid, imem_req_ready, imem_rsp_valid;
    logic [AW-1:0] imem_addr, redirect_pc, instr_pc;
    logic [IW-1:0] imem_rsp_data, instr;
    logic          redirect_valid, instr_valid, instr_ready;

    logic          imem_req_valid_w, imem_req_ready_w, imem_rsp_valid_w;
    logic [AW-1:0] imem_addr_w, redirect_pc_w, instr_pc_w;
    logic [IW-1:0] imem_rsp_data_w, instr_w;
    logic          redirect_valid_w, instr_valid_w, instr_ready_w;

    always #5 clk = ~clk;

    instruction_fetch #(.ADDR_W(AW), .INSTR_W(IW), .FIFO_DEPTH(DEPTH), .RESET_PC(32'h0)) u_dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc)
    );

    instruction_fetch #(.ADDR_W(AW), .INSTR_W(IW), .FIFO_DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid_w), .imem_req_ready(imem_req_ready_w), .imem_addr(imem_addr_w),
        .imem_rsp_valid(imem_rsp_valid_w), .imem_rsp_data(imem_rsp_data_w),
        .redirect_valid(redirect_valid_w), .redirect_pc(redirect_pc_w),
        .instr_valid(instr_valid_w), .instr_ready(instr_ready_w), .instr(instr_w), .instr_pc(instr_pc_w)
    );

    int n_pass = 0, n_fail = 0, n_total = 0;

    // Reference model: expected fetch address, expected decoder queue, request ownership.
    logic [AW-1:0] exp_fetch, req_pc_m;
    logic [AW-1:0] exp_q[$];
    bit            started, outstanding, stale;
    // Memory model.
    bit            m_pend;
    int            m_lat;
    logic [AW-1:0] m_addr;
    // Stimulus knobs.
    int            k_ready_pct, k_max_lat, k_iready_pct, k_redir_pct;
    int            want_redir;
    bit            redir_done;
    logic [AW-1:0] force_tgt;

    function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_fetch   = 32'h0;
        req_pc_m    = 32'h0;
        started     = 1'b0;
        outstanding = 1'b0;
        stale       = 1'b0;
        m_pend      = 1'b0;
        m_lat       = 0;
        m_addr      = 32'h0;
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_req_valid"},   imem_req_valid, 0);
        check({tag, "_imem_addr"},   imem_addr, 32'h0);
        check({tag, "_instr_valid"}, instr_valid, 0);
        check({tag, "_instr"},       instr, 32'h0);
        check({tag, "_instr_pc"},    instr_pc, 32'h0);
    endtask

    // One cycle: compare outputs, drive inputs for the next edge, advance the model. Entered at negedge.
    task automatic step();
        bit            exp_rv, rsp, acc, redir;
        logic [AW-1:0] tgt;
        exp_rv = started && !outstanding && (exp_q.size() < DEPTH);
        check("req_valid", imem_req_valid, exp_rv);
        if (exp_rv) check("imem_addr", imem_addr, exp_fetch);
        check("instr_valid", instr_valid, exp_q.size() > 0);
        if (exp_q.size() > 0) begin
            check("instr_pc", instr_pc, exp_q[0]);
            check("instr", instr, mem_word(exp_q[0]));
        end

        rsp = 1'b0;
        if (m_pend) begin
            if (m_lat == 0) begin
                rsp    = 1'b1;
                m_pend = 1'b0;
            end else m_lat--;
        end
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? mem_word(m_addr) : $urandom();
        imem_req_ready = ($urandom_range(99) < k_ready_pct);
        instr_ready    = ($urandom_range(99) < k_iready_pct);

        redir = ($urandom_range(99) < k_redir_pct);
        tgt   = $urandom();
        if ((want_redir == 1 && outstanding && !stale && !rsp) ||
            (want_redir == 2 && outstanding && !stale && rsp && exp_q.size() > 0 && instr_ready) ||
            (want_redir == 3)) begin
            redir      = 1'b1;
            tgt        = force_tgt;
            want_redir = 0;
            redir_done = 1'b1;
        end
        redirect_valid = redir;
        redirect_pc    = tgt;

        acc = imem_req_valid && imem_req_ready;
        if (acc) begin
            m_pend = 1'b1;
            m_addr = imem_addr;
            m_lat  = $urandom_range(k_max_lat);
        end

        if (redir) begin
            exp_q.delete();
            if (outstanding) begin
                if (rsp) begin
                    outstanding = 1'b0;
                    stale       = 1'b0;
                end else stale = 1'b1;
            end else if (exp_rv && imem_req_ready) begin
                outstanding = 1'b1;
                stale       = 1'b1;
            end
            exp_fetch = {tgt[AW-1:2], 2'b00};
        end else begin
            if (exp_q.size() > 0 && instr_ready) void'(exp_q.pop_front());
            if (rsp && outstanding) begin
                if (!stale) exp_q.push_back(req_pc_m);
                outstanding = 1'b0;
                stale       = 1'b0;
            end
            if (exp_rv && imem_req_ready) begin
                outstanding = 1'b1;
                stale       = 1'b0;
                req_pc_m    = exp_fetch;
                exp_fetch   = exp_fetch + 32'd4;
            end
        end
        started = 1'b1;
        @(negedge clk);
    endtask

    task automatic set_knobs(input int rdy, input int lat, input int irdy, input int rdr);
        k_ready_pct  = rdy;
        k_max_lat    = lat;
        k_iready_pct = irdy;
        k_redir_pct  = rdr;
    endtask

    initial begin
        logic [AW-1:0] seen_addr[$];
        logic [AW-1:0] seen_pc[$];
        bit            pend_w, found;

        reset          = 1'b1;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
        imem_req_ready_w = 1'b0; imem_rsp_valid_w = 1'b0; imem_rsp_data_w = '0;
        redirect_valid_w = 1'b0; redirect_pc_w = '0; instr_ready_w = 1'b0;
        want_redir = 0; redir_done = 1'b0; force_tgt = '0;
        set_knobs(100, 0, 100, 0);
        model_reset();
        repeat (2) @(negedge clk);
        reset_checks("reset");
        reset = 1'b0;

        // Single-cycle memory, decoder always ready: 0,4,8,C...
        repeat (12) step();

        // Decoder stalls: FIFO fills, requests stop; then drain and resume.
        set_knobs(100, 0, 0, 0);
        repeat (10) step();
        check("stall_fifo_full", 32'(exp_q.size()), 32'(DEPTH));
        set_knobs(100, 0, 100, 0);
        repeat (6) step();

        // Redirect to 0x103 while waiting on a response.
        set_knobs(100, 2, 100, 0);
        force_tgt = 32'h103; redir_done = 1'b0; want_redir = 1;
        for (int i = 0; i < 60 && !redir_done; i++) step();
        check("redir_in_wait_hit", redir_done, 1);
        repeat (10) step();

        // Redirect coincident with a response and a decoder pop.
        set_knobs(100, 2, 50, 0);
        force_tgt = 32'h100; redir_done = 1'b0; want_redir = 2;
        for (int i = 0; i < 400 && !redir_done; i++) step();
        check("redir_rsp_pop_hit", redir_done, 1);
        repeat (10) step();

        // Address wrap at the top of the address space.
        set_knobs(100, 0, 100, 0);
        force_tgt = 32'hFFFF_FFF8; redir_done = 1'b0; want_redir = 3;
        step();
        repeat (12) step();

        // Asynchronous reset while waiting with one word buffered.
        set_knobs(100, 2, 0, 0);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (outstanding && !stale && exp_q.size() == 1) found = 1'b1;
            else step();
        end
        check("reset_window_hit", found, 1);
        reset = 1'b1;
        #1;
        reset_checks("async_reset");
        model_reset();
        imem_rsp_valid = 1'b0; redirect_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        set_knobs(100, 0, 100, 0);
        repeat (10) step();

        // Randomized traffic.
        set_knobs(70, 3, 60, 5);
        repeat (2000) step();

        // Second instance starting near the top of the address space.
        set_knobs(0, 0, 0, 0);
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; redirect_valid = 1'b0;
        imem_req_ready_w = 1'b1; instr_ready_w = 1'b1;
        pend_w = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (instr_valid_w) seen_pc.push_back(instr_pc_w);
            imem_rsp_valid_w = pend_w;
            imem_rsp_data_w  = 32'hC0DE_0000 + 32'(c);
            pend_w = imem_req_valid_w;
            if (imem_req_valid_w) seen_addr.push_back(imem_addr_w);
            @(negedge clk);
        end
        imem_rsp_valid_w = 1'b0;
        check("wrap_addr_count", seen_addr.size() >= 3, 1);
        check("wrap_pc_count", seen_pc.size() >= 3, 1);
        if (seen_addr.size() >= 3) begin
            check("wrap_addr0", seen_addr[0], 32'hFFFF_FFF8);
            check("wrap_addr1", seen_addr[1], 32'hFFFF_FFFC);
            check("wrap_addr2", seen_addr[2], 32'h0000_0000);
        end
        if (seen_pc.size() >= 3) begin
            check("wrap_pc0", seen_pc[0], 32'hFFFF_FFF8);
            check("wrap_pc1", seen_pc[1], 32'hFFFF_FFFC);
            check("wrap_pc2", seen_pc[2], 32'h0000_0000);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
